fft_frame_sink: RTL and testbench

//  AXI-Stream slave at the output end of the trigger FFT: accepts one N-point result frame.

---
 rtl/fft_frame_sink.sv | 178 +++++++++++++++++
 tb/tb_fft_frame_sink.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sink.sv
// ============================================================================
// fft_frame_sink : AXI-Stream sink for one FFT frame; stores L1 bin magnitudes,
//                  tracks the peak bin and holds the frame until released.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_frame_sink #(
  parameter int N_POINTS    = 64,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int BIT_REVERSE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*DATA_W-1:0] i_s_axis_tdata,
  input  logic                i_s_axis_tvalid,
  input  logic                i_s_axis_tlast,
  output logic                o_s_axis_tready,
  input  logic                i_release,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W:0]     o_rd_data,
  output logic                o_frame_valid,
  output logic                o_frame_done,
  output logic                o_frame_error,
  output logic [ADDR_W-1:0]   o_peak_bin,
  output logic [DATA_W:0]     o_peak_mag
);

  localparam logic [1:0] S_RECV  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N_POINTS - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [ADDR_W-1:0]   r_count;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W:0]     r_mem [N_POINTS];
  logic [DATA_W:0]     r_rd_data;
  logic [ADDR_W-1:0]   r_peak_bin;
  logic [DATA_W:0]     r_peak_mag;
  logic                r_frame_done;
  logic                r_frame_error;

  logic                w_xfer;
  logic                w_recv_beat;
  logic                w_last_beat;
  logic                w_short;
  logic                w_long;
  logic                w_good;
  logic                w_restart;
  logic                w_peak_upd;
  logic [DATA_W-1:0]   w_re;
  logic [DATA_W-1:0]   w_im;
  logic [DATA_W:0]     w_abs_re;
  logic [DATA_W:0]     w_abs_im;
  logic [DATA_W:0]     w_mag;

  // ---------------- state machine ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RECV;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RECV: begin
        if (w_xfer && w_last_beat) begin
          w_next_state = i_s_axis_tlast ? S_HOLD : S_DRAIN;
        end
      end
      S_HOLD: begin
        if (i_release) begin
          w_next_state = S_RECV;
        end
      end
      S_DRAIN: begin
        if (w_xfer && i_s_axis_tlast) begin
          w_next_state = S_RECV;
        end
      end
      default: w_next_state = S_RECV;
    endcase
  end

  // tready is gated by reset so it is low before the state register settles.
  always_comb begin
    o_s_axis_tready = ~reset & (r_state != S_HOLD);
    o_frame_valid   = (r_state == S_HOLD);
    w_recv_beat     = w_xfer & (r_state == S_RECV);
  end

  assign w_xfer      = i_s_axis_tvalid & o_s_axis_tready;
  assign w_last_beat = (r_count == C_LAST);
  assign w_short     = w_recv_beat & i_s_axis_tlast & ~w_last_beat;
  assign w_long      = w_recv_beat & ~i_s_axis_tlast & w_last_beat;
  assign w_good      = w_recv_beat & i_s_axis_tlast & w_last_beat;
  assign w_restart   = ((r_state == S_HOLD) & i_release)
                     | ((r_state == S_DRAIN) & w_xfer & i_s_axis_tlast);

  // ---------------- magnitude ----------------
  // Sign-extend before negating so that the most negative input maps exactly.
  assign w_re     = i_s_axis_tdata[DATA_W-1:0];
  assign w_im     = i_s_axis_tdata[2*DATA_W-1:DATA_W];
  assign w_abs_re = w_re[DATA_W-1] ? -{w_re[DATA_W-1], w_re} : {1'b0, w_re};
  assign w_abs_im = w_im[DATA_W-1] ? -{w_im[DATA_W-1], w_im} : {1'b0, w_im};
  assign w_mag    = w_abs_re + w_abs_im;

  generate
    if (BIT_REVERSE != 0) begin : g_bitrev
      for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bit
        assign w_addr[gi] = r_count[ADDR_W-1-gi];
      end
    end else begin : g_natural
      assign w_addr = r_count;
    end
  endgenerate

  assign w_peak_upd = (w_mag > r_peak_mag)
                    | ((w_mag == r_peak_mag) & (w_addr < r_peak_bin));

  // ---------------- beat counter, peak, pulses ----------------
  // The counter wraps to zero on the final beat because N_POINTS is 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_peak_bin    <= '0;
      r_peak_mag    <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_done  <= w_good;
      r_frame_error <= w_short | w_long;
      if (w_short || w_restart) begin
        r_count    <= '0;
        r_peak_bin <= '0;
        r_peak_mag <= '0;
      end else if (w_recv_beat) begin
        r_count <= r_count + 1'b1;
        if (w_peak_upd) begin
          r_peak_bin <= w_addr;
          r_peak_mag <= w_mag;
        end
      end
    end
  end

  // ---------------- bin buffer ----------------
  always_ff @(posedge clk) begin
    if (w_recv_beat) begin
      r_mem[w_addr] <= w_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_frame_done  = r_frame_done;
  assign o_frame_error = r_frame_error;
  assign o_peak_bin    = r_peak_bin;
  assign o_peak_mag    = r_peak_mag;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sink.sv
// ============================================================================
// tb_fft_frame_sink : randomized frames checked against a frame-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fft_frame_sink;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic          rel, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW:0]   rd_data;
  logic          frame_valid, frame_done, frame_error;
  logic [AW-1:0] peak_bin;
  logic [DW:0]   peak_mag;

  int vectors = 0;
  int errors  = 0;

  fft_frame_sink #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1)) dut (
    .clk(clk), .reset(reset),
    .i_s_axis_tdata(tdata), .i_s_axis_tvalid(tvalid), .i_s_axis_tlast(tlast),
    .o_s_axis_tready(tready), .i_release(rel), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_frame_valid(frame_valid), .o_frame_done(frame_done),
    .o_frame_error(frame_error), .o_peak_bin(peak_bin), .o_peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) if (((k >> i) & 1) != 0) r |= (1 << (AW - 1 - i));
    return r;
  endfunction

  function automatic int mag_of(input logic [31:0] d);
    int re, im;
    re = int'($signed(d[15:0]));
    im = int'($signed(d[31:16]));
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
  endfunction

  // ---------------- frame-level reference model ----------------
  int  m_mem [N];
  bit  m_known [N];
  int  fr [N];
  int  m_cnt;
  bit  m_hold, m_drain, m_init;
  bit  exp_done, exp_err, exp_rd_known;
  int  exp_rd, exp_pbin, exp_pmag;

  initial begin
    m_init = 0; m_hold = 0; m_drain = 0; m_cnt = 0;
    exp_done = 0; exp_err = 0; exp_rd_known = 0; exp_rd = 0;
    exp_pbin = 0; exp_pmag = 0;
    for (int i = 0; i < N; i++) m_known[i] = 0;
    forever begin
      @(posedge clk);
      exp_done = 0;
      exp_err  = 0;
      if (reset) begin
        m_init = 1; m_hold = 0; m_drain = 0; m_cnt = 0;
        exp_rd = 0; exp_rd_known = 1;
      end else begin
        if (rd_en) begin
          exp_rd       = m_mem[rd_addr];
          exp_rd_known = m_known[rd_addr];
        end
        if (m_hold) begin
          if (rel) begin m_hold = 0; m_cnt = 0; end
        end else if (tvalid) begin
          if (m_drain) begin
            if (tlast) m_drain = 0;
          end else begin
            int a;
            a = bitrev(m_cnt);
            m_mem[a] = mag_of(tdata); m_known[a] = 1; fr[a] = m_mem[a];
            m_cnt++;
            if (tlast && m_cnt == N) begin
              m_hold = 1; exp_done = 1; m_cnt = 0;
              exp_pbin = 0; exp_pmag = fr[0];
              for (int b = 1; b < N; b++)
                if (fr[b] > exp_pmag) begin exp_pmag = fr[b]; exp_pbin = b; end
            end else if (tlast) begin
              exp_err = 1; m_cnt = 0;
            end else if (m_cnt == N) begin
              exp_err = 1; m_drain = 1; m_cnt = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("tready", tready, !reset && !m_hold);
        chk("frame_valid", frame_valid, m_hold);
        chk("frame_done", frame_done, exp_done);
        chk("frame_error", frame_error, exp_err);
        if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
        if (m_hold) begin
          chk("peak_bin", peak_bin, exp_pbin);
          chk("peak_mag", peak_mag, exp_pmag);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen(input int mode, input int k);
    logic [15:0] re, im;
    case (mode)
      1: begin re = 16'(k); im = 16'(-k); end
      2: begin re = (k == 5) ? 16'h8000 : 16'h0; im = re; end
      3: begin re = 16'd7; im = 16'd0; end
      default: begin
        re = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        im = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      end
    endcase
    return {im, re};
  endfunction

  task automatic send_frame(input int nbeats, input int last_at, input int mode);
    int  k = 0;
    int  budget = 0;
    bit  acc;
    while (k < nbeats) begin
      if (budget++ > 2000) begin
        vectors++; errors++;
        $display("FAIL send_timeout: got %0d beats accepted expected %0d", k, nbeats);
        break;
      end
      if ($urandom_range(0, 4) == 0) begin
        tvalid = 0; tlast = 0; tdata = 32'($urandom);
      end else begin
        tvalid = 1; tdata = gen(mode, k); tlast = (k == last_at);
      end
      acc = tvalid && tready;
      cycle();
      if (acc) k++;
    end
    tvalid = 0; tlast = 0;
  endtask

  task automatic read_lit(input int a, input int expv);
    rd_en = 1; rd_addr = AW'(a);
    cycle();
    rd_en = 0;
    chk("rd_lit", rd_data, expv);
  endtask

  task automatic read_model(input int a);
    rd_en = 1; rd_addr = AW'(a);
    cycle();
    rd_en = 0;
  endtask

  task automatic do_release();
    rel = 1;
    cycle();
    rel = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; tdata = '0; tvalid = 0; tlast = 0; rel = 0; rd_en = 0; rd_addr = '0;
    repeat (3) cycle();
    chk("rst_tready", tready, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 0;
    cycle();
    chk("post_rst_tready", tready, 1);

    // T1: ramp frame in bit-reversed order
    send_frame(64, 63, 1);
    chk("T1_done", frame_done, 1);
    cycle();
    chk("T1_valid", frame_valid, 1);
    chk("T1_peak_bin", peak_bin, 63);
    chk("T1_peak_mag", peak_mag, 126);
    for (int k = 0; k < N; k++) read_lit(bitrev(k), 2 * k);

    // T2: held frame ignores traffic until released
    tvalid = 1;
    for (int i = 0; i < 8; i++) begin
      tdata = 32'($urandom); tlast = 1'($urandom);
      cycle();
    end
    chk("T2_tready", tready, 0);
    tvalid = 0; tlast = 0;
    for (int i = 0; i < 8; i++) read_model(bitrev(i));
    do_release();
    chk("T2_valid", frame_valid, 0);
    chk("T2_tready_rel", tready, 1);
    do_release();

    // T3: short frame then good frame
    send_frame(11, 10, 0);
    chk("T3_error", frame_error, 1);
    cycle();
    send_frame(64, 63, 0);
    chk("T3_done", frame_done, 1);
    do_release();

    // T4: long frame drained, then good frame
    send_frame(69, 68, 0);
    cycle();
    send_frame(64, 63, 0);
    for (int a = 0; a < N; a++) read_model(a);
    do_release();

    // T5: most negative components on beat 5
    send_frame(64, 63, 2);
    cycle();
    read_lit(40, 65536);
    chk("T5_peak_bin", peak_bin, 40);
    chk("T5_peak_mag", peak_mag, 65536);
    do_release();

    // T6: all-equal bins, then reset mid-frame
    send_frame(64, 63, 3);
    cycle();
    chk("T6_peak_bin", peak_bin, 0);
    chk("T6_peak_mag", peak_mag, 7);
    do_release();
    send_frame(30, -1, 0);
    reset = 1;
    cycle(); cycle();
    reset = 0;
    cycle();
    send_frame(64, 63, 0);
    chk("T6_done_after_rst", frame_done, 1);
    do_release();

    // Random mix of good, short and long frames with stray releases
    for (int it = 0; it < 12; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) do_release();
      if (kind == 0) begin
        send_frame(64, 63, 0);
        repeat ($urandom_range(0, 5)) cycle();
        for (int r = 0; r < 8; r++) read_model($urandom_range(0, N - 1));
        do_release();
      end else if (kind == 1) begin
        int len;
        len = $urandom_range(1, 63);
        send_frame(len, len - 1, 0);
      end else begin
        int len;
        len = 64 + $urandom_range(1, 5);
        send_frame(len, len - 1, 0);
      end
      cycle();
    end

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
